mem_access_ctrl: RTL and testbench

Multi-cycle memory access controller for the X-Makina core. It sits between the CPU's two memory requesters (instruction fetch and data load/store) and the single shared memory port. It arbitrates between the requesters and decodes each granted address for misalignment, the PSW location and the exception-return value. It then either sequences a handshake with memory or completes the access locally, and returns data or a fault code to the requester.

---
 rtl/mem_access_ctrl.sv | 171 +++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Shared memory port controller for the X-Makina core: arbitrates fetch and data requesters,
// completes exception-return, misaligned and PSW accesses locally, and sequences the rest to memory.
module mem_access_ctrl #(
  parameter logic [15:0] EXC_RET  = 16'hFFFF,
  parameter logic [15:0] PSW_ADDR = 16'hFFFC,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        ifReq_i,
  input  logic [15:0] ifAddr_i,
  output logic        ifAck_o,
  output logic [15:0] ifData_o,
  output logic [1:0]  ifFault_o,
  output logic        excRet_o,
  input  logic        dReq_i,
  input  logic        dWrite_i,
  input  logic        dByte_i,
  input  logic [15:0] dAddr_i,
  input  logic [15:0] dWData_i,
  output logic        dAck_o,
  output logic [15:0] dRData_o,
  output logic [1:0]  dFault_o,
  input  logic [15:0] pswData_i,
  output logic [15:0] pswWData_o,
  output logic        pswWe_o,
  output logic        memEn_o,
  output logic        memWe_o,
  output logic [15:0] memAddr_o,
  output logic [15:0] memWData_o,
  output logic [1:0]  memLanes_o,
  input  logic [15:0] memRData_i,
  input  logic        memRdy_i
);

  typedef enum logic [1:0] {S_IDLE, S_MEM, S_RESP} state_t;
  typedef enum logic [1:0] {F_NONE = 2'd0, F_MISALIGN = 2'd1, F_TIMEOUT = 2'd2} fault_t;

  state_t      r_state, w_next_state;
  logic        r_last_data, r_sel_data, r_we, r_byte, r_exc, r_psw_we;
  logic [15:0] r_addr, r_wdata, r_psw_wdata, r_if_data, r_d_data;
  logic [1:0]  r_if_fault, r_d_fault;
  logic [3:0]  r_cnt;

  logic        w_grant, w_g_data, w_g_byte, w_g_write;
  logic        w_is_exc, w_is_mis, w_is_psw, w_local, w_timeout;
  logic        w_resp_load, w_resp_data_port, w_in_mem, w_in_resp;
  logic [15:0] w_g_addr, w_rd_lane, w_resp_data;
  fault_t      w_resp_fault;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned and infers a latch.
    w_next_state     = r_state;
    w_resp_load      = 1'b0;
    w_resp_data_port = r_sel_data;
    w_resp_data      = '0;
    w_resp_fault     = F_NONE;

    // Data wins a tie unless it was the last requester served.
    w_g_data  = dReq_i && (!ifReq_i || !r_last_data);
    w_grant   = (r_state == S_IDLE) && (ifReq_i || dReq_i);
    w_g_addr  = w_g_data ? dAddr_i : ifAddr_i;
    w_g_byte  = w_g_data && dByte_i;
    w_g_write = w_g_data && dWrite_i;
    w_is_exc  = !w_g_data && (ifAddr_i == EXC_RET);
    w_is_mis  = !w_is_exc && !w_g_byte && w_g_addr[0];
    w_is_psw  = w_g_data && !w_is_mis && (dAddr_i == PSW_ADDR);
    w_local   = w_is_exc || w_is_mis || w_is_psw;
    w_timeout = (r_cnt == 4'(TIMEOUT));
    w_rd_lane = r_addr[0] ? {8'h00, memRData_i[15:8]} : {8'h00, memRData_i[7:0]};

    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_next_state     = w_local ? S_RESP : S_MEM;
          w_resp_load      = w_local;
          w_resp_data_port = w_g_data;
          if (w_is_mis)
            w_resp_fault = F_MISALIGN;
          else if (w_is_psw && !dWrite_i)
            w_resp_data = dByte_i ? {8'h00, pswData_i[7:0]} : pswData_i;
        end
      end
      S_MEM: begin
        if (memRdy_i) begin
          w_next_state = S_RESP;
          w_resp_load  = 1'b1;
          w_resp_data  = r_byte ? w_rd_lane : memRData_i;
        end else if (w_timeout) begin
          w_next_state = S_RESP;
          w_resp_load  = 1'b1;
          w_resp_fault = F_TIMEOUT;
        end
      end
      S_RESP:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_last_data <= 1'b0;
      r_sel_data  <= 1'b0;
      r_we        <= 1'b0;
      r_byte      <= 1'b0;
      r_exc       <= 1'b0;
      r_psw_we    <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_psw_wdata <= '0;
      r_if_data   <= '0;
      r_d_data    <= '0;
      r_if_fault  <= '0;
      r_d_fault   <= '0;
      r_cnt       <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register sample pre-edge values, independent of statement order.
      if (w_grant) begin
        r_last_data <= w_g_data;
        r_sel_data  <= w_g_data;
        r_addr      <= w_g_addr;
        r_wdata     <= dWData_i;
        r_we        <= w_g_write;
        r_byte      <= w_g_byte;
        r_exc       <= w_is_exc;
        r_psw_we    <= w_is_psw && dWrite_i;
        r_cnt       <= '0;
        if (w_is_psw && dWrite_i)
          r_psw_wdata <= dByte_i ? {pswData_i[15:8], dWData_i[7:0]} : dWData_i;
      end else if (r_state == S_MEM) begin
        r_cnt <= r_cnt + 4'd1;
      end

      // Only the granted port's result registers change; the other port holds its last response.
      if (w_resp_load) begin
        if (w_resp_data_port) begin
          r_d_data  <= w_resp_data;
          r_d_fault <= w_resp_fault;
        end else begin
          r_if_data  <= w_resp_data;
          r_if_fault <= w_resp_fault;
        end
      end
    end
  end

  assign w_in_mem  = (r_state == S_MEM);
  assign w_in_resp = (r_state == S_RESP);

  assign memEn_o    = w_in_mem;
  assign memWe_o    = w_in_mem && r_we;
  assign memAddr_o  = w_in_mem ? r_addr : '0;
  assign memWData_o = (w_in_mem && r_we) ? (r_byte ? {2{r_wdata[7:0]}} : r_wdata) : '0;
  assign memLanes_o = !w_in_mem ? 2'd0 : !r_byte ? 2'd3 : r_addr[0] ? 2'd2 : 2'd1;

  assign ifAck_o    = w_in_resp && !r_sel_data;
  assign dAck_o     = w_in_resp && r_sel_data;
  assign excRet_o   = w_in_resp && r_exc;
  assign pswWe_o    = w_in_resp && r_psw_we;
  assign pswWData_o = r_psw_wdata;
  assign ifData_o   = r_if_data;
  assign ifFault_o  = r_if_fault;
  assign dRData_o   = r_d_data;
  assign dFault_o   = r_d_fault;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios plus randomized single accesses checked against
// an access-level model (expected latency, data, fault and memory-port view per access).
module tb_mem_access_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        ifReq_i, dReq_i, dWrite_i, dByte_i, memRdy_i;
  logic [15:0] ifAddr_i, dAddr_i, dWData_i, pswData_i, memRData_i;
  logic        ifAck_o, excRet_o, dAck_o, pswWe_o, memEn_o, memWe_o;
  logic [15:0] ifData_o, dRData_o, pswWData_o, memAddr_o, memWData_o;
  logic [1:0]  ifFault_o, dFault_o, memLanes_o;

  mem_access_ctrl dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .ifReq_i(ifReq_i), .ifAddr_i(ifAddr_i),
    .ifAck_o(ifAck_o), .ifData_o(ifData_o), .ifFault_o(ifFault_o), .excRet_o(excRet_o),
    .dReq_i(dReq_i), .dWrite_i(dWrite_i), .dByte_i(dByte_i),
    .dAddr_i(dAddr_i), .dWData_i(dWData_i),
    .dAck_o(dAck_o), .dRData_o(dRData_o), .dFault_o(dFault_o),
    .pswData_i(pswData_i), .pswWData_o(pswWData_o), .pswWe_o(pswWe_o),
    .memEn_o(memEn_o), .memWe_o(memWe_o), .memAddr_o(memAddr_o),
    .memWData_o(memWData_o), .memLanes_o(memLanes_o),
    .memRData_i(memRData_i), .memRdy_i(memRdy_i)
  );

  always #5 clk_i = ~clk_i;

  localparam int TIMEOUT = 15;

  int errors = 0;
  int checks = 0;

  // Model of the values each port should be holding from its last completed access.
  logic [15:0] exp_if_data, exp_d_data;
  logic [1:0]  exp_if_fault, exp_d_fault;
  bit          d_known;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_if_data  = '0;
    exp_d_data   = '0;
    exp_if_fault = '0;
    exp_d_fault  = '0;
    d_known      = 1'b1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_acks"}, {ifAck_o, dAck_o, excRet_o, pswWe_o}, 0);
    check({tag, "_mem_ctl"}, {memEn_o, memWe_o, memLanes_o}, 0);
    check({tag, "_mem_addr"}, memAddr_o, 0);
    check({tag, "_mem_wdata"}, memWData_o, 0);
    check({tag, "_if_resp"}, {ifData_o, ifFault_o}, 0);
    check({tag, "_d_resp"}, {dRData_o, dFault_o}, 0);
    check({tag, "_psw_wdata"}, pswWData_o, 0);
  endtask

  // One access from a single requester. rdy_cyc = MEM cycle (1-based) where ready is given, 0 = never.
  task automatic run_access(input string tag, input bit is_d, input bit wr, input bit by,
                            input logic [15:0] addr, input logic [15:0] wd, input logic [15:0] psw,
                            input logic [15:0] rdata, input int rdy_cyc);
    int          kind;  // 0 exception return, 1 misaligned, 2 PSW, 3 memory
    int          ack_cyc;
    bit          wr_eff, by_eff, mem_exp, ack_exp;
    logic [15:0] e_data, e_psw_w, e_mw;
    logic [1:0]  e_fault, e_lanes;

    wr_eff  = is_d && wr;
    by_eff  = is_d && by;
    e_data  = '0;
    e_fault = 2'd0;
    ack_cyc = 1;
    if (!is_d && addr == 16'hFFFF)       kind = 0;
    else if (!by_eff && addr[0])         begin kind = 1; e_fault = 2'd1; end
    else if (is_d && addr == 16'hFFFC) begin
      kind = 2;
      if (!wr_eff) e_data = by_eff ? (psw & 16'h00FF) : psw;
    end else begin
      kind = 3;
      if (rdy_cyc >= 1) begin
        ack_cyc = rdy_cyc + 1;
        e_data  = !by_eff ? rdata : (addr[0] ? (rdata >> 8) : (rdata & 16'h00FF));
      end else begin
        ack_cyc = TIMEOUT + 2;
        e_fault = 2'd2;
      end
    end
    e_psw_w = by_eff ? {psw[15:8], wd[7:0]} : wd;
    e_mw    = by_eff ? {wd[7:0], wd[7:0]} : wd;
    e_lanes = !by_eff ? 2'd3 : (addr[0] ? 2'd2 : 2'd1);

    @(posedge clk_i); #1;
    ifReq_i    = !is_d;
    ifAddr_i   = is_d ? 16'($urandom) : addr;
    dReq_i     = is_d;
    dWrite_i   = wr;
    dByte_i    = by;
    dAddr_i    = is_d ? addr : 16'($urandom);
    dWData_i   = wd;
    pswData_i  = psw;
    memRData_i = rdata;
    memRdy_i   = 1'($urandom_range(0, 1));

    for (int c = 1; c <= ack_cyc; c++) begin
      @(posedge clk_i); #1;
      memRdy_i = (kind == 3 && c < ack_cyc) ? (c == rdy_cyc) : 1'($urandom_range(0, 1));
      @(negedge clk_i);
      mem_exp = (kind == 3) && (c < ack_cyc);
      ack_exp = (c == ack_cyc);
      check({tag, "_memEn"}, memEn_o, mem_exp);
      if (mem_exp) begin
        check({tag, "_memAddr"}, memAddr_o, addr);
        check({tag, "_memWe"}, memWe_o, wr_eff);
        check({tag, "_memLanes"}, memLanes_o, e_lanes);
        if (wr_eff) check({tag, "_memWData"}, memWData_o, e_mw);
      end
      check({tag, "_ifAck"}, ifAck_o, ack_exp && !is_d);
      check({tag, "_dAck"}, dAck_o, ack_exp && is_d);
      check({tag, "_excRet"}, excRet_o, ack_exp && kind == 0);
      check({tag, "_pswWe"}, pswWe_o, ack_exp && kind == 2 && wr_eff);
      if (ack_exp) begin
        if (kind == 2 && wr_eff) check({tag, "_pswWData"}, pswWData_o, e_psw_w);
        if (is_d) begin
          if (!wr_eff) check({tag, "_dRData"}, dRData_o, e_data);
          check({tag, "_dFault"}, dFault_o, e_fault);
          check({tag, "_ifData_hold"}, ifData_o, exp_if_data);
          check({tag, "_ifFault_hold"}, ifFault_o, exp_if_fault);
          exp_d_data  = e_data;
          exp_d_fault = e_fault;
          d_known     = !wr_eff;
        end else begin
          check({tag, "_ifData"}, ifData_o, e_data);
          check({tag, "_ifFault"}, ifFault_o, e_fault);
          if (d_known) check({tag, "_dRData_hold"}, dRData_o, exp_d_data);
          check({tag, "_dFault_hold"}, dFault_o, exp_d_fault);
          exp_if_data  = e_data;
          exp_if_fault = e_fault;
        end
      end
    end
    @(posedge clk_i); #1;
    ifReq_i  = 1'b0;
    dReq_i   = 1'b0;
    memRdy_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          is_d, wr, by, saw_ack;
    int          sel, rdy, n_acks;
    bit          got_data [3];
    logic [15:0] addr;

    rst_n_i  = 1'b1;
    ifReq_i  = 0; dReq_i = 0; dWrite_i = 0; dByte_i = 0; memRdy_i = 0;
    ifAddr_i = 0; dAddr_i = 0; dWData_i = 0; pswData_i = 0; memRData_i = 0;
    model_reset();
    #2 rst_n_i = 1'b0;
    #20;
    check_outputs_zero("reset");
    rst_n_i = 1'b1;

    // Directed scenarios.
    run_access("rd_word",   1, 0, 0, 16'h0100, 16'h0000, 16'h0000, 16'hBEEF, 3);
    run_access("rd_byte_hi",1, 0, 1, 16'h0101, 16'h0000, 16'h0000, 16'hA55A, 1);
    run_access("wr_byte_lo",1, 1, 1, 16'h0100, 16'h0034, 16'h0000, 16'h0000, 2);
    run_access("wr_misal",  1, 1, 0, 16'h0103, 16'h5555, 16'h0000, 16'h0000, 1);
    run_access("exc_ret",   0, 0, 0, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 1);
    run_access("psw_rd",    1, 0, 0, 16'hFFFC, 16'h0000, 16'h1234, 16'h0000, 1);
    run_access("psw_wrb",   1, 1, 1, 16'hFFFC, 16'h00AB, 16'h1234, 16'h0000, 1);
    run_access("timeout",   1, 0, 0, 16'h0200, 16'h0000, 16'h0000, 16'h7777, 0);
    run_access("fetch_min", 0, 0, 0, 16'h0010, 16'h0000, 16'h0000, 16'h4321, 1);
    run_access("psw_rdb",   1, 0, 1, 16'hFFFC, 16'h0000, 16'hCD89, 16'h0000, 1);

    // Reset in the middle of a memory write.
    @(posedge clk_i); #1;
    dReq_i = 1; dWrite_i = 1; dByte_i = 0; dAddr_i = 16'h0400; dWData_i = 16'h9999; memRdy_i = 0;
    repeat (3) @(posedge clk_i);
    #2;
    check("midrst_memEn_before", memEn_o, 1'b1);
    rst_n_i = 1'b0;
    #1;
    check_outputs_zero("midrst");
    dReq_i = 0; dWrite_i = 0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #3 rst_n_i = 1'b1;
    saw_ack = 1'b0;
    repeat (20) begin
      @(negedge clk_i);
      if (ifAck_o || dAck_o || memEn_o) saw_ack = 1'b1;
    end
    check("midrst_quiet", saw_ack, 1'b0);

    // Both requesters held from the reset arbitration state: data, fetch, data.
    @(posedge clk_i); #1;
    ifReq_i = 1; ifAddr_i = 16'h0200; dReq_i = 1; dWrite_i = 0; dByte_i = 0; dAddr_i = 16'h0300;
    memRdy_i = 1; memRData_i = 16'h1111;
    n_acks = 0;
    for (int c = 0; c < 30 && n_acks < 3; c++) begin
      @(negedge clk_i);
      if (ifAck_o || dAck_o) begin
        check("arb_single_ack", ifAck_o && dAck_o, 1'b0);
        got_data[n_acks] = dAck_o;
        n_acks++;
      end
    end
    @(posedge clk_i); #1;
    ifReq_i = 0; dReq_i = 0; memRdy_i = 0;
    check("arb_ack_count", n_acks, 3);
    if (n_acks == 3) begin
      check("arb_first_data", got_data[0], 1'b1);
      check("arb_second_fetch", got_data[1], 1'b0);
      check("arb_third_data", got_data[2], 1'b1);
    end
    exp_if_data = 16'h1111; exp_if_fault = 2'd0;
    exp_d_data  = 16'h1111; exp_d_fault  = 2'd0;
    d_known     = 1'b1;

    // Randomized single accesses, biased toward the special addresses.
    for (int i = 0; i < 80; i++) begin
      is_d = 1'($urandom_range(0, 1));
      wr   = 1'($urandom_range(0, 1));
      by   = 1'($urandom_range(0, 1));
      sel  = $urandom_range(0, 9);
      addr = (sel == 0) ? 16'hFFFF : (sel == 1) ? 16'hFFFC : (sel == 2) ? 16'hFFFD : 16'($urandom);
      rdy  = $urandom_range(0, 7);
      run_access("rand", is_d, wr, by, addr, 16'($urandom), 16'($urandom), 16'($urandom), rdy);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
